four_bit_accumulator: RTL and testbench
=======================================

Name: four_bit_accumulator

Overview:
- Sequential stage that drives the team's 4-bit ripple adder.
- Accumulates a batch of NUM_OPS 4-bit operands, using the adder for every step.
- Returns a 4-bit running sum, the last step's carry and a sticky overflow flag.
- Sits between an operand source (valid/ready) and a result consumer (valid/ready).

Parameters:
- NUM_OPS, 4: operands per batch; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- start  input  1  begin a new batch; honoured only in IDLE
- in_valid  input  1  in_data is valid
- in_data  input  4  operand, bit 3 = MSB
- in_ready  output  1  block accepts an operand this cycle
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- out_sum  output  4  accumulated sum modulo 16
- out_carry  output  1  carry-out of the final addition
- out_ovf  output  1  sticky: a carry occurred on any addition in the batch
- busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, acc=0, last_c=0, ovf=0, cnt=0.
  - Outputs: in_ready=0, out_valid=0, out_sum=0, out_carry=0, out_ovf=0, busy=0.
  - Reset mid-batch discards all partial state. No result is emitted.
- States: IDLE, ACCUM, DONE. The encoding is internal.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> ACCUM. On the same edge acc<=0, last_c<=0, ovf<=0, cnt<=0.
- ACCUM:
  - in_ready=1.
  - An operand is accepted on a clk edge where in_valid=1 and in_ready=1.
  - On accept: {c,s} = acc + in_data through the 4-bit adder (carry-in 0). Then acc<=s, last_c<=c, ovf<=ovf|c, cnt<=cnt+1.
  - If accepted with cnt==NUM_OPS-1 -> DONE on the same edge.
  - in_valid=0 stalls with no state change. Idle cycles between operands are allowed.
- DONE:
  - in_ready=0, out_valid=1.
  - out_sum=acc, out_carry=last_c, out_ovf=ovf. These are held stable while out_valid=1 and out_ready=0.
  - out_valid=1 and out_ready=1 at an edge -> IDLE.
- Latency:
  - out_valid rises the cycle after the final operand is accepted.
  - Minimum batch is NUM_OPS+2 cycles from the start edge to the handshake edge (start, N accepts, 1 DONE cycle).
- Arithmetic: the sum wraps modulo 16. Example: 15+1 -> out_sum=0, carry=1, ovf=1.
- Boundary conditions:
  - start is ignored in ACCUM and DONE. A start in the IDLE cycle right after a DONE handshake is honoured.
  - in_valid is ignored outside ACCUM (in_ready=0, data dropped, source must hold).
  - NUM_OPS=1: a single accept goes straight to DONE; out_carry=out_ovf.
  - A result held in DONE blocks indefinitely; no new operands are accepted.
  - rst_n=0 overrides start and all handshakes on the same edge.
- out_sum/out_carry/out_ovf outside DONE: they show the internal registers (0 after reset) and carry no meaning unless out_valid=1.

Decomposition:
- Shared package:
  - state enum constants ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2.
  - OPND_W=4, CNT_W=4.
- Sub-module: instantiate four_bit_adder.
  - a0..a3 <= acc[0..3], b0..b3 <= in_data[0..3].
  - s0..s3 -> next acc; c3 -> carry.
- The adder is purely combinational. All registers live in four_bit_accumulator.

Test Plan:
- Reset then start, operands 1,1,1,1 back-to-back, out_ready=1 -> out_valid one cycle after the 4th accept; out_sum=4, out_carry=0, out_ovf=0; then IDLE, busy=0.
- Operands 13,8,0,0 -> 13+8 overflows (acc=5, c=1); final out_sum=5, out_carry=0, out_ovf=1 (sticky).
- Operands 10,7,15,15 with in_valid gaps of 2 cycles -> no spurious accepts; out_sum=15 (10+7=17->1, 1+15=16->0, 0+15=15), out_carry=0, out_ovf=1.
- In DONE, hold out_ready=0 for 5 cycles with in_valid=1 and start=1 -> in_ready=0, outputs stable, no state change; out_ready=1 -> IDLE next edge.
- rst_n=0 after 2 of 4 operands -> next edge IDLE, all outputs 0. A new batch 2,3,5,5 -> out_sum=15, out_ovf=0.
- NUM_OPS=1 instance: start, operand 15 -> DONE after 1 accept, out_sum=15, out_carry=0; then start, operand 0 -> out_sum=0, out_ovf=0.

Source files
------------

// File: rtl/four_bit_accumulator_pkg.sv
// Shared types and widths for the 4-bit accumulator and its ripple adder.
package four_bit_accumulator_pkg;

  localparam int unsigned OPND_W = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPND_W-1:0] sum;
    logic              carry;
    logic              ovf;
  } result_t;

endpackage

// File: rtl/four_bit_adder.sv
// Purely combinational 4-bit ripple-carry adder, carry-in tied to 0.
module four_bit_adder (
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic c3
);

  logic c0;
  logic c1;
  logic c2;

  assign s0 = a0 ^ b0;
  assign c0 = a0 & b0;
  assign s1 = a1 ^ b1 ^ c0;
  assign c1 = (a1 & b1) | (c0 & (a1 ^ b1));
  assign s2 = a2 ^ b2 ^ c1;
  assign c2 = (a2 & b2) | (c1 & (a2 ^ b2));
  assign s3 = a3 ^ b3 ^ c2;
  assign c3 = (a3 & b3) | (c2 & (a3 ^ b3));

endmodule

// File: rtl/four_bit_accumulator.sv
// Batch accumulator: sums NUM_OPS 4-bit operands through the ripple adder,
// reporting the wrapped sum, the final carry and a sticky overflow.
module four_bit_accumulator #(
  parameter int unsigned NUM_OPS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sum,
  output logic       out_carry,
  output logic       out_ovf,
  output logic       busy
);

  import four_bit_accumulator_pkg::*;

  state_t            state;
  state_t            state_nx;
  result_t           res;
  result_t           res_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic [OPND_W-1:0] add_sum;
  logic              add_c;

  four_bit_adder u_adder (
    .a0 (res.sum[0]),
    .a1 (res.sum[1]),
    .a2 (res.sum[2]),
    .a3 (res.sum[3]),
    .b0 (in_data[0]),
    .b1 (in_data[1]),
    .b2 (in_data[2]),
    .b3 (in_data[3]),
    .s0 (add_sum[0]),
    .s1 (add_sum[1]),
    .s2 (add_sum[2]),
    .s3 (add_sum[3]),
    .c3 (add_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_nx = state;
    res_nx   = res;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_ACCUM;
          res_nx   = '0;
          cnt_nx   = '0;
        end
      end
      ST_ACCUM: begin
        if (in_valid && in_ready) begin
          res_nx.sum   = add_sum;
          res_nx.carry = add_c;
          res_nx.ovf   = res.ovf | add_c;
          cnt_nx       = cnt + CNT_W'(1);
          if (cnt == CNT_W'(NUM_OPS - 1)) begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track it exactly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      res       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      res       <= res_nx;
      cnt       <= cnt_nx;
      in_ready  <= (state_nx == ST_ACCUM);
      out_valid <= (state_nx == ST_DONE);
      busy      <= (state_nx == ST_ACCUM) || (state_nx == ST_DONE);
    end
  end

  assign out_sum   = res.sum;
  assign out_carry = res.carry;
  assign out_ovf   = res.ovf;

endmodule

// File: tb/tb_four_bit_accumulator.sv
// Self-checking bench: NUM_OPS=4 and NUM_OPS=1 instances against a
// running-total reference model, plus directed literal checks.
module tb_four_bit_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start;
  logic [1:0] in_valid;
  logic [1:0] out_ready;
  logic [3:0] in_data [2];
  logic [1:0] in_ready;
  logic [1:0] out_valid;
  logic [1:0] out_carry;
  logic [1:0] out_ovf;
  logic [1:0] busy;
  logic [3:0] out_sum [2];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Reference model: phase 0 idle, 1 collecting, 2 holding result
  int m_phase [2];
  int m_total [2];
  int m_cnt   [2];
  bit m_lastc [2];

  always #5 clk = ~clk;

  four_bit_accumulator #(.NUM_OPS(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start[0]),
    .in_valid  (in_valid[0]),
    .in_data   (in_data[0]),
    .in_ready  (in_ready[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_sum   (out_sum[0]),
    .out_carry (out_carry[0]),
    .out_ovf   (out_ovf[0]),
    .busy      (busy[0])
  );

  four_bit_accumulator #(.NUM_OPS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start[1]),
    .in_valid  (in_valid[1]),
    .in_data   (in_data[1]),
    .in_ready  (in_ready[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_sum   (out_sum[1]),
    .out_carry (out_carry[1]),
    .out_ovf   (out_ovf[1]),
    .busy      (busy[1])
  );

  function automatic int nops(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_phase[i] <= 0;
        m_total[i] <= 0;
        m_cnt[i]   <= 0;
        m_lastc[i] <= 1'b0;
      end else begin
        case (m_phase[i])
          0: if (start[i]) begin
            m_phase[i] <= 1;
            m_total[i] <= 0;
            m_cnt[i]   <= 0;
            m_lastc[i] <= 1'b0;
          end
          1: if (in_valid[i]) begin
            m_lastc[i] <= ((m_total[i] % 16) + int'(in_data[i])) >= 16;
            m_total[i] <= m_total[i] + int'(in_data[i]);
            m_cnt[i]   <= m_cnt[i] + 1;
            if (m_cnt[i] + 1 == nops(i)) m_phase[i] <= 2;
          end
          default: if (out_ready[i]) m_phase[i] <= 0;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("model_in_ready[%0d]", i), int'(in_ready[i]), int'(m_phase[i] == 1));
        check($sformatf("model_out_valid[%0d]", i), int'(out_valid[i]), int'(m_phase[i] == 2));
        check($sformatf("model_busy[%0d]", i), int'(busy[i]), int'(m_phase[i] != 0));
        check($sformatf("model_out_sum[%0d]", i), int'(out_sum[i]), m_total[i] % 16);
        check($sformatf("model_out_carry[%0d]", i), int'(out_carry[i]), int'(m_lastc[i]));
        check($sformatf("model_out_ovf[%0d]", i), int'(out_ovf[i]), int'(m_total[i] >= 16));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [3:0] d, input int gap);
    int k;
    in_valid[i] = 1'b0;
    repeat (gap) tick();
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    k = 0;
    while (!in_ready[i] && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready[i]) begin
      check($sformatf("send_timeout[%0d]", i), 0, 1);
    end else begin
      tick();
    end
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i);
    int k;
    k = 0;
    while (!out_valid[i] && k < 50) begin
      tick();
      k++;
    end
    check($sformatf("wait_valid[%0d]", i), int'(out_valid[i]), 1);
  endtask

  task automatic check_res(input int i, input string tag, input int s, input int c, input int o);
    check({tag, "_valid"}, int'(out_valid[i]), 1);
    check({tag, "_sum"}, int'(out_sum[i]), s);
    check({tag, "_carry"}, int'(out_carry[i]), c);
    check({tag, "_ovf"}, int'(out_ovf[i]), o);
  endtask

  task automatic handshake(input int i, input int delay);
    out_ready[i] = 1'b0;
    repeat (delay) tick();
    out_ready[i] = 1'b1;
    tick();
    out_ready[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int i;
    int ops;
    rst_n      = 1'b0;
    start      = '0;
    in_valid   = '0;
    out_ready  = '0;
    in_data[0] = '0;
    in_data[1] = '0;
    tick();
    tick();
    chk_en = 1'b1;
    check("reset_sum", int'(out_sum[0]), 0);
    check("reset_busy", int'(busy[0]), 0);
    check("reset_in_ready", int'(in_ready[0]), 0);
    rst_n = 1'b1;
    tick();

    // 1+1+1+1, consumer always ready
    out_ready[0] = 1'b1;
    do_start(0);
    for (int k = 0; k < 4; k++) send(0, 4'd1, 0);
    check_res(0, "ones", 4, 0, 0);
    tick();
    check("ones_idle_busy", int'(busy[0]), 0);
    out_ready[0] = 1'b0;

    // 13+8 overflows, sticky ovf
    do_start(0);
    send(0, 4'd13, 0); send(0, 4'd8, 0); send(0, 4'd0, 0); send(0, 4'd0, 0);
    check_res(0, "sticky", 5, 0, 1);
    handshake(0, 0);

    // Gapped operands
    do_start(0);
    send(0, 4'd10, 2); send(0, 4'd7, 2); send(0, 4'd15, 2); send(0, 4'd15, 2);
    check_res(0, "gaps", 15, 0, 1);
    handshake(0, 1);

    // Held result ignores start and operands
    do_start(0);
    for (int k = 0; k < 4; k++) send(0, 4'd3, 0);
    start[0]    = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = 4'd9;
    repeat (5) begin
      tick();
      check("hold_in_ready", int'(in_ready[0]), 0);
      check_res(0, "hold", 12, 0, 0);
    end
    start[0]     = 1'b0;
    in_valid[0]  = 1'b0;
    handshake(0, 0);
    check("hold_release_valid", int'(out_valid[0]), 0);
    check("hold_release_busy", int'(busy[0]), 0);

    // Reset mid-batch
    do_start(0);
    send(0, 4'd7, 0); send(0, 4'd9, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", int'(busy[0]), 0);
    check("midrst_in_ready", int'(in_ready[0]), 0);
    check("midrst_sum", int'(out_sum[0]), 0);
    check("midrst_ovf", int'(out_ovf[0]), 0);
    do_start(0);
    send(0, 4'd2, 0); send(0, 4'd3, 0); send(0, 4'd5, 0); send(0, 4'd5, 0);
    check_res(0, "postrst", 15, 0, 0);
    handshake(0, 0);

    // Single-operand instance, restart right after the handshake
    do_start(1);
    send(1, 4'd15, 0);
    check_res(1, "n1_a", 15, 0, 0);
    handshake(1, 0);
    do_start(1);
    check("n1_restart_busy", int'(busy[1]), 1);
    send(1, 4'd0, 0);
    check_res(1, "n1_b", 0, 0, 0);
    handshake(1, 2);

    // Randomized batches checked by the model
    for (int t = 0; t < 40; t++) begin
      i   = int'($urandom_range(0, 1));
      ops = nops(i);
      repeat ($urandom_range(0, 2)) tick();
      do_start(i);
      for (int k = 0; k < ops; k++) send(i, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      wait_valid(i);
      handshake(i, int'($urandom_range(0, 3)));
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
